fp8_operand_sequencer: RTL and testbench

FP8_OPERAND_SEQUENCER -- requirements
Module: fp8_operand_sequencer

---
 rtl/fp8_pkg.sv | 28 ++
 rtl/fp8_pair_fifo.sv | 62 ++++++
 rtl/fp8_operand_sequencer.sv | 149 ++++++++++++++
 tb/tb_fp8_operand_sequencer.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fp8_pkg.sv
// fp8_pkg -- shared definitions for the FP8 operand sequencer.
//   FP8 byte layout: sign[7], exponent[6:3], mantissa[2:0].
//   EXP_INF     : exponent pattern of a saturated value.
//   seq_state_e : issue FSM states.
package fp8_pkg;

    localparam int FP8_W    = 8;
    localparam int SIGN_BIT = 7;
    localparam int EXP_MSB  = 6;
    localparam int EXP_LSB  = 3;
    localparam int MAN_MSB  = 2;
    localparam int MAN_LSB  = 0;
    localparam int PAIR_W   = 2 * FP8_W;

    localparam logic [EXP_MSB-EXP_LSB:0] EXP_INF = 4'b1111;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_HOLD  = 2'd3
    } seq_state_e;

    function automatic logic fp8_is_inf(input logic [FP8_W-1:0] v);
        return v[EXP_MSB:EXP_LSB] == EXP_INF;
    endfunction

endpackage

// File: rtl/fp8_pair_fifo.sv
// fp8_pair_fifo -- operand-pair FIFO, 16 bits wide, DEPTH entries (power of two).
//   clk, rst_n       : clock, synchronous active-low reset
//   i_push/i_push_data : write a {A,B} pair
//   i_pop/o_pop_data : head pair (read is combinational from the head entry)
//   o_full/o_empty   : derived from an occupancy count one bit wider than the pointers
module fp8_pair_fifo
    import fp8_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_push,
    input  logic [PAIR_W-1:0] i_push_data,
    input  logic              i_pop,
    output logic [PAIR_W-1:0] o_pop_data,
    output logic              o_full,
    output logic              o_empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW-1:0] PTR_ONE  = 1;
    localparam logic [AW:0]   CNT_ONE  = 1;
    localparam logic [AW:0]   CNT_FULL = (AW + 1)'(DEPTH);

    logic [PAIR_W-1:0] r_mem [DEPTH];
    logic [AW-1:0]     r_wr_ptr;
    logic [AW-1:0]     r_rd_ptr;
    logic [AW:0]       r_count;
    logic              w_push;
    logic              w_pop;

    // Guards keep the pointers consistent even if a caller misbehaves.
    assign w_push = i_push && !o_full;
    assign w_pop  = i_pop  && !o_empty;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_ONE;
                2'b01:   r_count <= r_count - CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage needs no reset: the count alone decides what is valid.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= i_push_data;
    end

    assign o_pop_data = r_mem[r_rd_ptr];
    assign o_full     = (r_count == CNT_FULL);
    assign o_empty    = (r_count == '0);

endmodule

// File: rtl/fp8_operand_sequencer.sv
// fp8_operand_sequencer -- pairs incoming FP8 bytes (A then B), queues the pairs,
// and issues one pair at a time to an external adder with a fixed latency,
// capturing the sum for a valid/ready consumer.
//   clk, rst_n                 : clock, synchronous active-low reset
//   in_data/in_valid/in_ready  : byte stream; slot-A bytes always accepted
//   add_a/add_b/add_en         : operands and enable to the adder stage
//   add_result                 : adder sum, sampled ADD_LATENCY cycles after add_en rises
//   out_data/out_valid/out_ready/out_inf : captured sum and its saturation flag
//   busy                       : anything queued, in flight, or a half pair held
module fp8_operand_sequencer
    import fp8_pkg::*;
#(
    parameter int ADD_LATENCY = 2,
    parameter int PAIR_DEPTH  = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [FP8_W-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [FP8_W-1:0] add_a,
    output logic [FP8_W-1:0] add_b,
    output logic             add_en,
    input  logic [FP8_W-1:0] add_result,
    output logic [FP8_W-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_inf,
    output logic             busy
);

    localparam logic [3:0] LAT_LOAD = 4'(ADD_LATENCY - 1);
    localparam logic [3:0] CNT_ONE  = 4'd1;

    seq_state_e        r_state;
    seq_state_e        w_state_nxt;
    logic              r_slot_b;
    logic [FP8_W-1:0]  r_hold_a;
    logic [3:0]        r_cnt;
    logic [FP8_W-1:0]  r_add_a;
    logic [FP8_W-1:0]  r_add_b;
    logic [FP8_W-1:0]  r_out_data;
    logic              r_out_inf;

    logic              w_in_fire;
    logic              w_push;
    logic              w_pop;
    logic              w_capture;
    logic              w_add_en;
    logic              w_fifo_full;
    logic              w_fifo_empty;
    logic [PAIR_W-1:0] w_head;

    // Only a B byte needs FIFO space; an A byte just lands in the holding register.
    assign in_ready  = !(r_slot_b && w_fifo_full);
    assign w_in_fire = in_valid && in_ready;
    assign w_push    = w_in_fire && r_slot_b;

    fp8_pair_fifo #(
        .DEPTH (PAIR_DEPTH)
    ) u_pair_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_push      (w_push),
        .i_push_data ({r_hold_a, in_data}),
        .i_pop       (w_pop),
        .o_pop_data  (w_head),
        .o_full      (w_fifo_full),
        .o_empty     (w_fifo_empty)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        w_capture   = 1'b0;
        w_add_en    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (!w_fifo_empty) begin
                    w_pop       = 1'b1;
                    w_state_nxt = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                w_add_en    = 1'b1;
                w_state_nxt = ST_WAIT;
            end
            ST_WAIT: begin
                w_add_en = 1'b1;
                if (r_cnt == 4'd0) begin
                    w_capture   = 1'b1;
                    w_state_nxt = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (out_ready) w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_slot_b   <= 1'b0;
            r_hold_a   <= '0;
            r_cnt      <= '0;
            r_add_a    <= '0;
            r_add_b    <= '0;
            r_out_data <= '0;
            r_out_inf  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;

            if (w_in_fire) begin
                if (!r_slot_b) r_hold_a <= in_data;
                r_slot_b <= !r_slot_b;
            end

            // Operands only change on a pop, so they hold through issue, wait and hold.
            if (w_pop) begin
                r_add_a <= w_head[PAIR_W-1:FP8_W];
                r_add_b <= w_head[FP8_W-1:0];
            end

            // ISSUE lasts one cycle and WAIT lasts ADD_LATENCY cycles, so the
            // capture edge lands ADD_LATENCY cycles after add_en first rises.
            if (r_state == ST_ISSUE) begin
                r_cnt <= LAT_LOAD;
            end else if (r_state == ST_WAIT && r_cnt != 4'd0) begin
                r_cnt <= r_cnt - CNT_ONE;
            end

            if (w_capture) begin
                r_out_data <= add_result;
                r_out_inf  <= fp8_is_inf(add_result);
            end
        end
    end

    assign add_a     = r_add_a;
    assign add_b     = r_add_b;
    assign add_en    = w_add_en;
    assign out_data  = r_out_data;
    assign out_inf   = r_out_inf;
    assign out_valid = (r_state == ST_HOLD);
    assign busy      = !w_fifo_empty || (r_state != ST_IDLE) || r_slot_b;

endmodule

// File: tb/tb_fp8_operand_sequencer.sv
// Scoreboard bench for fp8_operand_sequencer. The adder stage is a bench model
// whose sum is only correct in the cycle ADD_LATENCY after add_en first rises,
// so mistimed captures show up as wrong out_data.
module tb_fp8_operand_sequencer;

    localparam int L = 2;
    localparam int D = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] add_a, add_b, add_result, out_data;
    logic       add_en, out_valid, out_ready, out_inf, busy;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] res;
    } exp_t;
    exp_t sb[$];

    int         n_cmp = 0;
    int         n_err = 0;
    int         en_cnt = 0;
    logic       tie_mode = 1'b0;
    logic [7:0] tie_val = 8'h00;
    logic       rdy_rand = 1'b0;
    logic       rdy_rnd = 1'b0;
    logic       rdy_val = 1'b1;
    logic       have_a = 1'b0;
    logic [7:0] a_byte = 8'h00;

    fp8_operand_sequencer #(.ADD_LATENCY(L), .PAIR_DEPTH(D)) dut (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .add_a(add_a), .add_b(add_b), .add_en(add_en),
        .add_result(add_result), .out_data(out_data), .out_valid(out_valid),
        .out_ready(out_ready), .out_inf(out_inf), .busy(busy)
    );

    always #5 clk = ~clk;

    // Adder stage model: any function of the operands will do, the sequencer
    // never does arithmetic itself.
    function automatic logic [7:0] adder_f(input logic [7:0] a, input logic [7:0] b);
        return (a + b) ^ 8'h3C;
    endfunction

    always @(posedge clk) en_cnt <= add_en ? en_cnt + 1 : 0;

    assign add_result = tie_mode ? tie_val :
                        ((add_en && en_cnt == L) ? adder_f(add_a, add_b) : ~adder_f(add_a, add_b));
    assign out_ready  = rdy_rand ? rdy_rnd : rdy_val;

    initial forever begin
        @(posedge clk); #1;
        rdy_rnd = 1'($urandom_range(0, 1));
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic fail_bound(input string nm);
        n_cmp++;
        n_err++;
        $display("FAIL %s: bound expired", nm);
    endtask

    // Bench-side pairing: an accepted byte either opens a pair or completes it.
    task automatic record(input logic [7:0] b);
        exp_t e;
        if (!have_a) begin
            a_byte = b;
            have_a = 1'b1;
        end else begin
            e.a   = a_byte;
            e.b   = b;
            e.res = tie_mode ? tie_val : adder_f(a_byte, b);
            sb.push_back(e);
            have_a = 1'b0;
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        logic acc;
        logic ok;
        ok = 1'b0;
        in_data  = b;
        in_valid = 1'b1;
        for (int t = 0; t < 300; t++) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk); #1;
            if (acc) begin
                ok = 1'b1;
                break;
            end
        end
        in_valid = 1'b0;
        if (ok) record(b);
        else fail_bound("send_byte");
    endtask

    task automatic wait_valid(input string nm);
        logic seen;
        seen = 1'b0;
        for (int t = 0; t < 50; t++) begin
            @(negedge clk);
            if (out_valid) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) fail_bound(nm);
    endtask

    task automatic drain(input string nm);
        logic done;
        done = 1'b0;
        for (int t = 0; t < 3000; t++) begin
            @(negedge clk);
            if (sb.size() == 0 && !busy) begin
                done = 1'b1;
                break;
            end
        end
        if (!done) fail_bound(nm);
        @(posedge clk); #1;
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_add_a"},     add_a,     0);
        chk({tag, "_add_b"},     add_b,     0);
        chk({tag, "_add_en"},    add_en,    0);
        chk({tag, "_out_data"},  out_data,  0);
        chk({tag, "_out_valid"}, out_valid, 0);
        chk({tag, "_out_inf"},   out_inf,   0);
        chk({tag, "_busy"},      busy,      0);
        chk({tag, "_in_ready"},  in_ready,  1);
    endtask

    // Monitor: every cycle out_valid is up, the head of the scoreboard must be on
    // the outputs; the entry retires on the handshake.
    always @(negedge clk) begin
        if (rst_n && out_valid) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL spurious_out_valid: got out_data 0x%0h with nothing expected", out_data);
            end else begin
                chk("out_data", out_data, sb[0].res);
                chk("out_inf",  out_inf,  (sb[0].res[6:3] == 4'b1111));
                chk("add_a",    add_a,    sb[0].a);
                chk("add_b",    add_b,    sb[0].b);
                if (out_ready) void'(sb.pop_front());
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int stall_idx;
        logic seen;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_vals("rst");
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Basic pair with a tied adder result and latency measurement
        tie_mode = 1'b1;
        tie_val  = 8'h44;
        rdy_val  = 1'b1;
        send_byte(8'h38);
        send_byte(8'h40);
        seen = 1'b0;
        for (int t = 0; t < 20; t++) begin
            @(negedge clk);
            if (add_en) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) fail_bound("add_en_rise");
        chk("issue_add_a", add_a, 8'h38);
        chk("issue_add_b", add_b, 8'h40);
        n = 0;
        for (int t = 0; t < 40; t++) begin
            @(negedge clk);
            n++;
            if (out_valid) break;
        end
        // pop cycle + issue + ADD_LATENCY wait cycles = 2 + L cycles pop-to-valid
        chk("add_en_to_valid_cycles", n, L + 1);
        chk("basic_out_data", out_data, 8'h44);
        drain("drain_basic");

        // Saturation flag
        tie_val = 8'h78;
        send_byte(8'($urandom));
        send_byte(8'($urandom));
        wait_valid("wait_inf1");
        chk("inf_78", out_inf, 1);
        drain("drain_inf1");
        tie_val = 8'h70;
        send_byte(8'($urandom));
        send_byte(8'($urandom));
        wait_valid("wait_inf0");
        chk("inf_70", out_inf, 0);
        drain("drain_inf0");
        tie_mode = 1'b0;

        // Held output: monitor checks stability each cycle, one retirement only
        rdy_val = 1'b0;
        send_byte(8'hA5);
        send_byte(8'h5A);
        wait_valid("wait_hold");
        repeat (10) @(negedge clk);
        @(posedge clk); #1;
        rdy_val = 1'b1;
        drain("drain_hold");
        chk("hold_busy_after", busy, 0);

        // Back-pressure: one pair sits in HOLD and D pairs fill the FIFO, so the
        // B byte of pair D+2 is the first one refused.
        rdy_val   = 1'b0;
        stall_idx = -1;
        for (int k = 0; k < 16; k++) begin
            in_data  = 8'($urandom);
            in_valid = 1'b1;
            @(negedge clk);
            if (!in_ready) begin
                stall_idx = k;
                break;
            end
            @(posedge clk); #1;
            record(in_data);
        end
        chk("stall_byte_index", stall_idx, 2 * (D + 1) + 1);
        repeat (3) @(negedge clk);
        chk("stall_in_ready_held", in_ready, 0);
        @(posedge clk); #1;
        rdy_val = 1'b1;
        send_byte(in_data);
        drain("drain_full");

        // Lone A byte: no issue, but busy
        send_byte(8'h3B);
        n = 0;
        repeat (6) begin
            @(negedge clk);
            if (add_en) n++;
        end
        chk("lone_a_add_en_cycles", n, 0);
        chk("lone_a_busy", busy, 1);
        @(posedge clk); #1;
        send_byte(8'hC1);
        drain("drain_lone");

        // Reset in WAIT with a half pair held
        send_byte(8'h12);
        send_byte(8'h34);
        send_byte(8'h56);
        seen = 1'b0;
        for (int t = 0; t < 20; t++) begin
            @(negedge clk);
            if (add_en) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) fail_bound("add_en_before_reset");
        @(posedge clk); #1;
        rst_n = 1'b0;
        sb.delete();
        have_a = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check_reset_vals("midrst");
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        @(posedge clk); #1;
        send_byte(8'h11);
        send_byte(8'h22);
        drain("drain_after_reset");

        // Randomized traffic with random back-pressure
        rdy_rand = 1'b1;
        for (int p = 0; p < 80; p++) begin
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk); #1;
            end
            send_byte(8'($urandom));
        end
        rdy_rand = 1'b0;
        rdy_val  = 1'b1;
        drain("drain_random");
        chk("final_busy", busy, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
